// File: rtl/clb_cfg_scan_ctrl.sv
// clb_cfg_scan_ctrl: stages CLB LUT words, commits them atomically, settles, then scans the fabric output.
// Optional continuous rescan via CLB_CTRL_CONT_SCAN_EN (adds cont_scan input).
module clb_cfg_scan_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [1:0] cfg_addr,
    input  logic [1:0] cfg_lut,
    input  logic       cfg_last,
    input  logic       cfg_mode,
    output logic [1:0] clb1,
    output logic [1:0] clb2,
    output logic [1:0] clb3,
    output logic [1:0] clb4,
    output logic       sel_dat,
    output logic [1:0] sel_clb,
    input  logic       fab_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
`ifdef CLB_CTRL_CONT_SCAN_EN
    input  logic       cont_scan,
`endif
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, COMMIT, SETTLE, SCAN, DONE} state_t;
    state_t state, state_n;
    logic [1:0] sh [4];
    logic       mode_sh;
    logic [3:0] cnt;
    logic       acc, hs, rescan;
    assign acc       = cfg_valid & cfg_ready;
    assign hs        = res_valid & res_ready;
`ifdef CLB_CTRL_CONT_SCAN_EN
    assign rescan    = cont_scan & ~cfg_valid;
`else
    assign rescan    = 1'b0;
`endif
    assign cfg_ready = (state == IDLE) & ~rst;
    assign busy      = state != IDLE;
    assign res_valid = state == DONE;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = (acc && cfg_last) ? COMMIT : IDLE;
            COMMIT:  state_n = SETTLE;
            SETTLE:  state_n = (cnt == 4'd0) ? SCAN : SETTLE;
            SCAN:    state_n = (sel_clb == 2'd3) ? DONE : SCAN;
            DONE:    state_n = hs ? (rescan ? SCAN : IDLE) : DONE;
            default: state_n = IDLE;
        endcase
    end
    // sel_clb doubles as the scan index; it wraps back to 0 after the last sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sh       <= '{default: '0};
            mode_sh  <= 1'b0;
            cnt      <= 4'd0;
            clb1     <= 2'd0;
            clb2     <= 2'd0;
            clb3     <= 2'd0;
            clb4     <= 2'd0;
            sel_dat  <= 1'b0;
            sel_clb  <= 2'd0;
            res_data <= 4'd0;
        end else begin
            state <= state_n;
            if (acc) begin
                sh[cfg_addr] <= cfg_lut;
                if (cfg_last) mode_sh <= cfg_mode;
            end
            if (state == COMMIT) begin
                clb1    <= sh[0];
                clb2    <= sh[1];
                clb3    <= sh[2];
                clb4    <= sh[3];
                sel_dat <= mode_sh;
                cnt     <= 4'(SETTLE_CYCLES - 1);
                sel_clb <= 2'd0;
            end
            if (state == SETTLE) cnt <= cnt - 4'd1;
            if (state == SCAN) begin
                res_data[sel_clb] <= fab_out;
                sel_clb           <= sel_clb + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_clb_cfg_scan_ctrl.sv
// tb_clb_cfg_scan_ctrl: lockstep bench for SETTLE_CYCLES=2 and =1 instances against an XOR-LUT fabric model.
`timescale 1ns/1ps
module tb_clb_cfg_scan_ctrl;
    localparam int SC [2] = '{2, 1};
`ifdef CLB_CTRL_CONT_SCAN_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif
    logic clk = 0, rst = 1, cfg_valid = 0, cfg_last = 0, cfg_mode = 0, res_ready = 0, cont_scan = 0, flip = 0;
    logic [1:0] cfg_addr = 0, cfg_lut = 0;
    logic cfg_ready [2], sel_dat [2], fab [2], res_valid [2], busy [2];
    logic [1:0] sel_clb [2];
    logic [1:0] clbv [2][4];
    logic [3:0] res_data [2];
    logic ff [2][4];
    int errors = 0, checks = 0;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 2; g++) begin : gd
        clb_cfg_scan_ctrl #(.SETTLE_CYCLES(SC[g])) u (
            .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[g]),
            .cfg_addr(cfg_addr), .cfg_lut(cfg_lut), .cfg_last(cfg_last), .cfg_mode(cfg_mode),
            .clb1(clbv[g][0]), .clb2(clbv[g][1]), .clb3(clbv[g][2]), .clb4(clbv[g][3]),
            .sel_dat(sel_dat[g]), .sel_clb(sel_clb[g]), .fab_out(fab[g]),
            .res_valid(res_valid[g]), .res_ready(res_ready), .res_data(res_data[g]),
`ifdef CLB_CTRL_CONT_SCAN_EN
            .cont_scan(cont_scan),
`endif
            .busy(busy[g])
        );
    end
    function automatic logic lut_out(input logic [1:0] v, input int i, input logic f);
        return ^v ^ (f && i == 2);
    endfunction
    always_comb for (int d = 0; d < 2; d++)
        fab[d] = sel_dat[d] ? ff[d][sel_clb[d]] : lut_out(clbv[d][sel_clb[d]], int'(sel_clb[d]), flip);
    always @(posedge clk) for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++)
        ff[d][i] <= lut_out(clbv[d][i], i, flip);
    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0d required=%0d at %0t", nm, d, act, exp, $time);
        end
    endtask
    // Reference model: t counts edges since the last beat was accepted (scan entry is t=S+1)
    bit m_idle [2], m_valid [2], m_mode [2], m_odat [2], m_rst [2];
    int t [2];
    logic [1:0] m_sh [2][4];
    logic [1:0] m_out [2][4];
    logic [3:0] m_res [2];
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            m_rst[d] = rst;
            if (rst) begin
                m_idle[d] = 1; t[d] = -1; m_valid[d] = 0; m_mode[d] = 0; m_odat[d] = 0; m_res[d] = 0;
                for (int i = 0; i < 4; i++) begin m_sh[d][i] = 0; m_out[d][i] = 0; end
            end else if (m_idle[d]) begin
                if (cfg_valid) begin
                    m_sh[d][cfg_addr] = cfg_lut;
                    if (cfg_last) begin m_mode[d] = cfg_mode; m_idle[d] = 0; t[d] = 0; end
                end
            end else if (m_valid[d]) begin
                if (res_ready) begin
                    m_valid[d] = 0;
                    if (CONT && cont_scan && !cfg_valid) t[d] = SC[d] + 1;
                    else begin m_idle[d] = 1; t[d] = -1; end
                end
            end else begin
                t[d]++;
                if (t[d] == 1) begin
                    for (int i = 0; i < 4; i++) m_out[d][i] = m_sh[d][i];
                    m_odat[d] = m_mode[d];
                end
                if (t[d] == SC[d] + 5) begin
                    m_valid[d] = 1;
                    for (int i = 0; i < 4; i++) m_res[d][i] = ^m_out[d][i] ^ (flip && i == 2);
                end
            end
        end
    end
    always @(posedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("cfg_ready", d, cfg_ready[d], m_idle[d] && !rst);
            chk("busy", d, busy[d], !m_idle[d]);
            chk("res_valid", d, res_valid[d], m_valid[d]);
            chk("sel_dat", d, sel_dat[d], m_odat[d]);
            for (int i = 0; i < 4; i++) chk("clb", d, clbv[d][i], m_out[d][i]);
            if (m_valid[d] || m_rst[d]) chk("res_data", d, res_data[d], m_res[d]);
            if (m_rst[d]) chk("sel_clb_rst", d, sel_clb[d], 0);
            else if (!m_valid[d] && t[d] > SC[d] && t[d] <= SC[d] + 4) chk("sel_clb_scan", d, sel_clb[d], t[d] - SC[d] - 1);
        end
    end
    task automatic beat(input logic [1:0] a, input logic [1:0] l, input logic last, input logic mode);
        @(negedge clk);
        cfg_valid = 1; cfg_addr = a; cfg_lut = l; cfg_last = last; cfg_mode = mode; res_ready = 0;
        @(posedge clk);
    endtask
    task automatic rel();
        @(negedge clk);
        cfg_valid = 0; cfg_last = 0; res_ready = 0;
    endtask
    task automatic hs(input logic cv);
        @(negedge clk);
        cfg_valid = cv; res_ready = 1;
        @(posedge clk);
    endtask
    task automatic run(input int e0, input int e1, input logic [3:0] er, output logic [7:0] seq);
        int l0, l1;
        l0 = -1; l1 = -1; seq = 0;
        rel();
        for (int n = 1; n <= 40 && (l0 < 0 || l1 < 0); n++) begin
            @(posedge clk); #3;
            if (n >= e0 - 4 && n < e0) seq = {seq[5:0], sel_clb[0]};
            if (res_valid[0] && l0 < 0) l0 = n;
            if (res_valid[1] && l1 < 0) l1 = n;
        end
        chk("latency", 0, l0, e0);
        chk("latency", 1, l1, e1);
        chk("result", 0, res_data[0], er);
        chk("result", 1, res_data[1], er);
    endtask
    initial begin
        logic [7:0] seq;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 0;
        @(posedge clk); #3;
        chk("ready_after_rst", 0, cfg_ready[0], 1);
        beat(0, 1, 0, 0); beat(1, 3, 0, 0); beat(2, 2, 0, 0); beat(3, 0, 1, 0);
        run(7, 6, 4'b0101, seq);
        chk("sel_seq", 0, seq, 8'h1B);
        hs(0);
        beat(0, 1, 0, 0); beat(1, 3, 0, 0); beat(2, 2, 0, 0); beat(3, 0, 1, 1);
        run(7, 6, 4'b0101, seq);
        hs(0);
        beat(3, 1, 1, 0);
        run(7, 6, 4'b1101, seq);
        hs(0);
        beat(0, 1, 0, 0); beat(0, 0, 1, 0);
        run(7, 6, 4'b1100, seq);
        hs(0);
        beat(1, 1, 1, 0);
        run(7, 6, 4'b1110, seq);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            cfg_valid = 1; cfg_addr = 2; cfg_lut = 3; cfg_last = 1;
            @(posedge clk); #3;
            chk("bp_valid", 0, res_valid[0], 1);
            chk("bp_data", 0, res_data[0], 4'b1110);
            chk("bp_ready", 0, cfg_ready[0], 0);
        end
        hs(0); #3;
        chk("idle_after_hs", 0, busy[0], 0);
        beat(3, 1, 1, 0);
        run(7, 6, 4'b1110, seq);
        hs(0);
        beat(0, 3, 1, 0);
        rel();
        repeat (4) @(posedge clk);
        @(negedge clk) rst = 1;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_valid", 0, res_valid[0], 0);
        chk("rst_busy", 1, busy[1], 0);
        chk("rst_clb1", 0, clbv[0][0], 0);
        @(negedge clk) rst = 0;
        beat(2, 1, 1, 0);
        run(7, 6, 4'b0100, seq);
`ifdef CLB_CTRL_CONT_SCAN_EN
        cont_scan = 1;
        hs(0);
        run(4, 4, 4'b0100, seq);
        flip = 1;
        hs(0);
        run(4, 4, 4'b0000, seq);
        hs(1);
        rel();
        @(posedge clk); #3;
        chk("cont_exit_busy", 0, busy[0], 0);
        chk("cont_exit_ready", 1, cfg_ready[1], 1);
`endif
        repeat (2) @(posedge clk);
        #4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clb_cfg_scan_ctrl.md
# clb_cfg_scan_ctrl

Configuration and readout sequencer for the 4-CLB fabric. It accepts LUT configuration words over a valid/ready stream and stages them in shadow registers. It then commits them atomically to the four CLB LUT inputs and the shared combinational/registered select, waits for the fabric to settle, and walks the switch select across all four CLBs. The sampled fabric output is returned as one 4-bit result with a valid/ready handshake.

## Interface
Parameters:
- SETTLE_CYCLES, 2, cycles waited after commit before scanning; legal range 1..15 (4-bit counter).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  configuration word valid
- cfg_ready  out  1  high in IDLE only, forced 0 while rst=1
- cfg_addr  in  2  target CLB: 0→CLB1 … 3→CLB4
- cfg_lut  in  2  LUT input bits for the addressed CLB
- cfg_last  in  1  final word of a configuration set; triggers commit
- cfg_mode  in  1  registered-path select; captured only on the last beat
- clb1, clb2, clb3, clb4  out  2 each  LUT drive to the fabric CLBs
- sel_dat  out  1  fabric mux select: 0 = LUT direct, 1 = LUT via flip-flop
- sel_clb  out  2  switch-matrix select into the fabric
- fab_out  in  1  fabric switch output (combinational from sel_clb)
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_data  out  4  bit i = fabric output with sel_clb=i
- busy  out  1  state != IDLE

## Operation
- Storage: four 2-bit shadow registers and a 1-bit mode shadow.
- Shadow writes occur only on an accepted beat (cfg_valid & cfg_ready).
- Unwritten addresses keep their previous shadow value. A repeated address in one set resolves as last write wins.
- States and transitions:
  - IDLE: cfg_ready=1. Every accepted beat writes shadow[cfg_addr]. An accepted beat with cfg_last=1 also captures cfg_mode and moves to COMMIT.
  - COMMIT (1 cycle): clb1..clb4 ← shadows, sel_dat ← mode shadow, settle counter ← SETTLE_CYCLES-1, sel_clb ← 0. Moves to SETTLE.
  - SETTLE: counter decrements each cycle. When the counter reads 0, moves to SCAN with idx=0.
  - SCAN: sel_clb=idx. At the end of each cycle, res_data[idx] ← fab_out and idx increments. After idx=3 is sampled, moves to DONE.
  - DONE: res_valid=1 and res_data is held stable. On res_valid & res_ready, moves to IDLE and res_valid drops on the next edge.
- clb1..clb4, sel_dat and sel_clb hold their values outside COMMIT/SCAN. The fabric stays configured while IDLE.
- cfg_* inputs are ignored outside IDLE.
- rst high at any cycle, including mid-SCAN or in DONE:
  - next state is IDLE; all shadows and outputs return to 0.
  - any partial result is discarded.

## Timing
- Reset values: clb1..clb4=00, sel_dat=0, sel_clb=00, res_valid=0, res_data=0000, busy=0, cfg_ready=0 while rst=1 and 1 on the first cycle after.
- Let the last beat be accepted at edge T0:
  - COMMIT occupies T0→T1; fabric drives update at T1.
  - SETTLE occupies SETTLE_CYCLES cycles; SCAN is entered at T1+SETTLE_CYCLES.
  - Samples are taken at edges T1+S+1 through T1+S+4.
  - res_valid rises at T1+S+4, i.e. 5+SETTLE_CYCLES edges after T0 (7 with default).
- The sel_dat=1 path needs one edge after commit for the fabric flip-flop to capture. SETTLE_CYCLES≥1 guarantees this.
- Throughput: one configuration set per 6+SETTLE_CYCLES cycles plus words loaded plus res_ready wait.
- The earliest next cfg beat is the cycle after the DONE handshake.

## Configuration
- Macro CLB_CTRL_CONT_SCAN_EN.
- Defined:
  - Adds input port cont_scan (1 bit).
  - On the DONE handshake, if cont_scan=1 and cfg_valid=0, the block goes directly to SCAN with idx=0. It skips IDLE/COMMIT/SETTLE, so the fabric is re-sampled continuously with no reconfiguration.
  - Otherwise it goes to IDLE. busy stays 1 across rescans.
- Undefined: port absent; DONE always returns to IDLE.

## Test plan
- Reset check: hold rst for 3 cycles mid-SCAN → all outputs reach their reset values on the next edge; cfg_ready=1 one cycle after rst drops.
- Direct mode, fabric model LUT = XOR: load CLB1=01, CLB2=11, CLB3=10, CLB4=00 with mode 0 and last on the 4th beat.
  - res_valid rises 7 edges after the last beat; res_data=4'b0101.
  - sel_clb sequence during SCAN is 0,1,2,3.
- Registered mode with the same words and mode 1 → res_data=4'b0101.
  - Repeat with SETTLE_CYCLES=1 → still 4'b0101 and latency = 6.
- Partial update and overwrite: after the previous set, send single beat addr=3, lut=01, last=1 → res_data=4'b1101.
  - Send addr 0 twice (01 then 00) with last → bit0=0.
- Backpressure: hold res_ready=0 for 10 cycles in DONE → res_valid and res_data stable, cfg_ready=0, cfg beats not accepted; release → IDLE next edge.
- With CLB_CTRL_CONT_SCAN_EN, cont_scan=1, cfg_valid=0: after the handshake, SCAN restarts the next cycle without reconfiguration.
  - Toggle the fabric model's CLB3 result → the next res_data reflects the change.
  - Raise cfg_valid before the handshake → block returns to IDLE.
